// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 active-low row-scanning keypad reader with frame debounce and valid/ready key events.
// Define KEYPAD_REPEAT_EN to auto-repeat a single held key after REPEAT_DELAY frames, then every REPEAT_RATE.
module keypad_scan #(
    parameter int CLK_DIV_W      = 13,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_DELAY   = 64,
    parameter int REPEAT_RATE    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  col_in,
    output logic [3:0]  row_out,
    input  logic        key_ready,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic        key_down,
    output logic        key_overrun,
    output logic [15:0] pressed_map
);
    localparam int SW = DEBOUNCE_SCANS > 1 ? $clog2(DEBOUNCE_SCANS) : 1;
    localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS - 1);

    typedef enum logic [1:0] {IDLE, HELD, MULTI} state_t;

    logic [3:0]           col_meta, col_sync;
    logic [CLK_DIV_W-1:0] div;
    logic [1:0]           r;
    logic [11:0]          snap;
    logic [15:0]          prev, frame;
    logic [SW-1:0]        stable, stable_nxt;
    logic                 tick, frame_end, single, emit, rpt_fire;
    logic [3:0]           code, held, emit_code;
    state_t               state, state_nxt;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            col_meta <= '1;
            col_sync <= '1;
        end else begin
            col_meta <= col_in;
            col_sync <= col_meta;
        end

    assign tick       = &div;
    assign frame_end  = tick && r == 2'd3;
    // snap shifts in rows 0..2; row 3 is taken straight from the synchronizer at frame end
    assign frame      = {~col_sync, snap};
    assign stable_nxt = frame != prev ? '0 : (stable == STABLE_MAX ? stable : stable + 1'b1);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            div         <= '0;
            r           <= '0;
            row_out     <= 4'b1110;
            snap        <= '0;
            prev        <= '0;
            stable      <= '0;
            pressed_map <= '0;
            key_down    <= 1'b0;
        end else begin
            div <= div + 1'b1;
            if (tick) begin
                snap    <= {~col_sync, snap[11:4]};
                r       <= r + 2'd1;
                row_out <= ~(4'b0001 << (r + 2'd1));
            end
            if (frame_end) begin
                prev   <= frame;
                stable <= stable_nxt;
                if (stable_nxt == STABLE_MAX && frame != pressed_map) begin
                    pressed_map <= frame;
                    key_down    <= |frame;
                end
            end
        end

    always_comb begin
        code = '0;
        for (int i = 0; i < 16; i++)
            if (pressed_map[i]) code = 4'(i);
    end

    assign single = |pressed_map && ~|(pressed_map & (pressed_map - 16'd1));

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = single ? HELD : (|pressed_map ? MULTI : IDLE);
            HELD:    state_nxt = ~|pressed_map ? IDLE : (!single || code != held ? MULTI : HELD);
            MULTI:   state_nxt = ~|pressed_map ? IDLE : MULTI;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        emit      = (state == IDLE && single) || rpt_fire;
        emit_code = state == IDLE ? code : held;
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int RMAX = REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);
    logic [RW-1:0] rpt;
    assign rpt_fire = state == HELD && state_nxt == HELD && frame_end && rpt == RW'(1);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) rpt <= '0;
        else if (state != HELD) rpt <= RW'(REPEAT_DELAY);
        else if (frame_end) rpt <= rpt == RW'(1) ? RW'(REPEAT_RATE) : rpt - 1'b1;
`else
    // repeat timing parameters have no effect without auto-repeat
    assign rpt_fire = (REPEAT_DELAY < 0) && (REPEAT_RATE < 0);
`endif

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            key_valid   <= 1'b0;
            key_code    <= '0;
            key_overrun <= 1'b0;
            held        <= '0;
        end else begin
            if (state == IDLE && single) held <= code;
            if (emit && (!key_valid || key_ready)) begin
                key_valid   <= 1'b1;
                key_code    <= emit_code;
                key_overrun <= 1'b0;
            end else if (emit) begin
                key_overrun <= 1'b1;
            end else if (key_valid && key_ready) begin
                key_valid   <= 1'b0;
                key_overrun <= 1'b0;
            end
        end
endmodule
